// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the flexible synchronous FIFO family.
//   FIFO_MODE_REG  : read data registered, valid the cycle after an accepted read
//   FIFO_MODE_FWFT : first-word-fall-through, head word always presented
//   fifo_cnt_w()   : width of pointers/count; one extra bit above the address
//                    width so that "full" (count == DEPTH) is representable
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// -----------------------------------------------------------------------------
// fifo_dpram
// Storage array for syn_fifo_flex: 2**ADDR_WIDTH words of DATA_WIDTH bits.
// Contents are not reset.
// Ports:
//   clk    in  clock for the write port
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write word
//   raddr  in  read address (asynchronous read)
//   rdata  out word at raddr
// -----------------------------------------------------------------------------
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/syn_fifo_flex.sv
// -----------------------------------------------------------------------------
// syn_fifo_flex
// Single-clock FIFO with selectable read mode (registered / FWFT), programmable
// almost-full / almost-empty thresholds, synchronous flush and sticky
// overflow / underflow flags.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   flush            synchronous clear of pointers, count and error flags
//   w_en, w_data     write request and word
//   r_en             read request (FWFT: pop the presented head)
//   r_data           read word
//   is_empty/is_full count == 0 / count == DEPTH
//   almost_empty     count <= AE_LEVEL
//   almost_full      count >= AF_LEVEL
//   data_avail       words stored
//   room_avail       free slots
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
// -----------------------------------------------------------------------------
module syn_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = FIFO_MODE_REG,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  is_empty,
    output logic                  is_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   data_avail,
    output logic [ADDR_WIDTH:0]   room_avail,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("syn_fifo_flex: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("syn_fifo_flex: AE_LEVEL out of range 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("syn_fifo_flex: FWFT must be 0 or 1");
    end

    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc, rd_acc, mem_we;

    assign is_empty     = (count_q == {CNT_W{1'b0}});
    assign is_full      = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign data_avail   = count_q;
    assign room_avail   = DEPTH_C - count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Acceptance is judged on the current count, so a full FIFO still takes a
    // read while rejecting the simultaneous write (and vice versa when empty).
    assign wr_acc = w_en & ~is_full;
    assign rd_acc = r_en & ~is_empty;
    assign mem_we = wr_acc & ~flush;

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (w_data),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, count, sticky flags and output register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        rdata_d  = rdata_q;
        if (flush) begin
            // Flush wins over any request on the same edge; r_data is kept.
            wr_ptr_d = {CNT_W{1'b0}};
            rd_ptr_d = {CNT_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end else if (w_en) begin
                ovf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
                if (FWFT == FIFO_MODE_REG) begin
                    rdata_d = mem_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
            end else if (r_en) begin
                unf_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {CNT_W{1'b0}};
            rd_ptr_q <= {CNT_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
        end
    end

    // FWFT presents the head word straight from the array.
    assign r_data = (FWFT == FIFO_MODE_FWFT) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_syn_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_syn_fifo_flex
// Drives one registered-read and one FWFT instance of syn_fifo_flex with the
// same stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_syn_fifo_flex;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       w_en;
    logic [7:0] w_data;
    logic       r_en;

    logic [7:0] r_data_s       [2];
    logic       is_empty_s     [2];
    logic       is_full_s      [2];
    logic       almost_empty_s [2];
    logic       almost_full_s  [2];
    logic [4:0] data_avail_s   [2];
    logic [4:0] room_avail_s   [2];
    logic       overflow_s     [2];
    logic       underflow_s    [2];

    int checks = 0;
    int errors = 0;

    // Reference model: stored words, sticky flags, registered-read output.
    logic [7:0] q_m [$];
    bit         ovf_m;
    bit         unf_m;
    logic [7:0] rd0_m;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       f;
        int         exp_cnt;
        bit         exp_ovf;
        bit         exp_unf;
    } vec_t;

    vec_t tbl [10];

    syn_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0),
                    .AF_LEVEL(12), .AE_LEVEL(2)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_data(w_data),
        .r_en(r_en), .r_data(r_data_s[0]), .is_empty(is_empty_s[0]),
        .is_full(is_full_s[0]), .almost_empty(almost_empty_s[0]),
        .almost_full(almost_full_s[0]), .data_avail(data_avail_s[0]),
        .room_avail(room_avail_s[0]), .overflow(overflow_s[0]),
        .underflow(underflow_s[0])
    );

    syn_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1),
                    .AF_LEVEL(12), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_data(w_data),
        .r_en(r_en), .r_data(r_data_s[1]), .is_empty(is_empty_s[1]),
        .is_full(is_full_s[1]), .almost_empty(almost_empty_s[1]),
        .almost_full(almost_full_s[1]), .data_avail(data_avail_s[1]),
        .room_avail(room_avail_s[1]), .overflow(overflow_s[1]),
        .underflow(underflow_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        rd0_m = 8'h00;
    endtask

    // Compare every status output of both instances against the model.
    task automatic check_status();
        int cnt;
        cnt = q_m.size();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("data_avail[%0d]", i), int'(data_avail_s[i]), cnt);
            chk($sformatf("room_avail[%0d]", i), int'(room_avail_s[i]), 16 - cnt);
            chk($sformatf("is_empty[%0d]", i), int'(is_empty_s[i]), int'(cnt == 0));
            chk($sformatf("is_full[%0d]", i), int'(is_full_s[i]), int'(cnt == 16));
            chk($sformatf("almost_empty[%0d]", i), int'(almost_empty_s[i]), int'(cnt <= 2));
            chk($sformatf("almost_full[%0d]", i), int'(almost_full_s[i]), int'(cnt >= 12));
            chk($sformatf("overflow[%0d]", i), int'(overflow_s[i]), int'(ovf_m));
            chk($sformatf("underflow[%0d]", i), int'(underflow_s[i]), int'(unf_m));
        end
        chk("r_data_reg", int'(r_data_s[0]), int'(rd0_m));
        if (cnt > 0) begin
            chk("r_data_fwft", int'(r_data_s[1]), int'(q_m[0]));
        end
    endtask

    // One clock of stimulus; entered and left at a falling edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
        bit rd_ok;
        bit wr_ok;
        w_en   = w;
        w_data = d;
        r_en   = r;
        flush  = f;
        #1;
        if (!f && r && q_m.size() > 0) begin
            chk("fwft_head_before_pop", int'(r_data_s[1]), int'(q_m[0]));
        end
        @(posedge clk);
        #1;
        if (f) begin
            q_m.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            rd_ok = r && (q_m.size() > 0);
            wr_ok = w && (q_m.size() < 16);
            if (w && !wr_ok) ovf_m = 1'b1;
            if (r && !rd_ok) unf_m = 1'b1;
            if (rd_ok) rd0_m = q_m.pop_front();
            if (wr_ok) q_m.push_back(d);
        end
        check_status();
        w_en  = 1'b0;
        r_en  = 1'b0;
        flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'h44, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};

        rst    = 1'b1;
        flush  = 1'b0;
        w_en   = 1'b0;
        w_data = 8'h00;
        r_en   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_status();
        rst = 1'b0;
        @(negedge clk);

        // Table-driven short sequences with constant expectations.
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].w, tbl[k].d, tbl[k].r, tbl[k].f);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("tbl%0d_cnt[%0d]", k, i), int'(data_avail_s[i]), tbl[k].exp_cnt);
                chk($sformatf("tbl%0d_ovf[%0d]", k, i), int'(overflow_s[i]), int'(tbl[k].exp_ovf));
                chk($sformatf("tbl%0d_unf[%0d]", k, i), int'(underflow_s[i]), int'(tbl[k].exp_unf));
            end
        end

        // Fill to full, overflow, then drain in order.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b0);
            if (k == 10) chk("af_before_12th", int'(almost_full_s[0]), 0);
            if (k == 11) chk("af_after_12th", int'(almost_full_s[0]), 1);
        end
        chk("room_full", int'(room_avail_s[0]), 0);
        chk("is_full", int'(is_full_s[1]), 1);
        step(1'b1, 8'h10, 1'b0, 1'b0);
        chk("ovf_17th", int'(overflow_s[0]), 1);
        chk("cnt_17th", int'(data_avail_s[1]), 16);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_order_reg", int'(r_data_s[0]), k);
        end

        // Read past empty.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_past_empty", int'(underflow_s[0]), 1);
        chk("r_data_held", int'(r_data_s[0]), 15);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Concurrent read/write at count 8, pointers wrap twice.
        for (int k = 0; k < 8; k++) step(1'b1, 8'h80 + 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 8'h20 + 8'(k), 1'b1, 1'b0);
        chk("concurrent_cnt", int'(data_avail_s[0]), 8);
        chk("concurrent_delay", int'(r_data_s[0]), 8'h20 + 8'd31);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Single word into empty FIFO.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_not_empty", int'(is_empty_s[1]), 0);
        chk("fwft_shows_a5", int'(r_data_s[1]), 8'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_empty_after_pop", int'(is_empty_s[1]), 1);
        chk("reg_a5_after_read", int'(r_data_s[0]), 8'hA5);

        // Flush with pending write at count 5 and overflow set.
        for (int k = 0; k < 17; k++) step(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_flush_cnt", int'(data_avail_s[0]), 5);
        chk("pre_flush_ovf", int'(overflow_s[0]), 1);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("flush_cnt", int'(data_avail_s[1]), 0);
        chk("flush_room", int'(room_avail_s[1]), 16);
        chk("flush_ovf", int'(overflow_s[1]), 0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post_flush_head", int'(r_data_s[1]), 8'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 7; k++) step(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0);
        w_en   = 1'b1;
        w_data = 8'h77;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_status();
        chk("async_rst_cnt", int'(data_avail_s[0]), 0);
        w_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
